// File: rtl/fft_8_frame_ctrl.sv
// fft_8_frame_ctrl: serial-to-parallel frame sequencer around an 8-point FFT core.
// Loads 8 complex samples, pulses the core start, waits for done, captures
// the result and streams the 8 bins back out in order.
// Optional feature macro: FFT_CTRL_TIMEOUT_EN (abort a frame stuck in WAIT).
//
// Handshake semantics (both streams): a beat transfers on a rising edge where
// valid && ready are both high. A producer holding valid keeps its data stable
// until the transfer. in_ready and out_valid depend only on registered state.
module fft_8_frame_ctrl #(
  parameter int DW             = 16,
  parameter int N              = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [DW-1:0]   in_real,
  input  logic [DW-1:0]   in_imag,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [DW-1:0]   out_real,
  output logic [DW-1:0]   out_imag,
  output logic            out_last,
  output logic            core_start,
  output logic [N*DW-1:0] core_in_real,
  output logic [N*DW-1:0] core_in_imag,
  input  logic [N*DW-1:0] core_out_real,
  input  logic [N*DW-1:0] core_out_imag,
  input  logic            core_done,
  output logic            busy,
  output logic [15:0]     frame_cnt,
  output logic            err_timeout,
  output logic [1:0]      dbg_state
);

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    START  = 2'd1,
    WAIT   = 2'd2,
    UNLOAD = 2'd3
  } state_t;

  localparam logic [2:0] LAST_IDX = 3'(N - 1);

  state_t        state_q, state_d;
  logic [2:0]    idx_q, idx_d;
  logic [15:0]   frame_cnt_q, frame_cnt_d;
  logic          core_start_q;
  logic          in_we, out_we;
  logic          tmo_hit;
  logic [DW-1:0] in_re_q  [N];
  logic [DW-1:0] in_im_q  [N];
  logic [DW-1:0] out_re_q [N];
  logic [DW-1:0] out_im_q [N];

`ifdef FFT_CTRL_TIMEOUT_EN
  logic [15:0] wait_cnt_q;
  logic        err_q;

  // Timeout fires on the WAIT cycle that would take the counter to the limit;
  // a core_done in that same cycle takes priority.
  assign tmo_hit = (state_q == WAIT) && !core_done &&
                   (wait_cnt_q == 16'(TIMEOUT_CYCLES - 1));

  // Wait counter: cleared on the way into WAIT, counts WAIT cycles without done.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt_q <= '0;
    end else if (state_q == START) begin
      wait_cnt_q <= '0;
    end else if (state_q == WAIT && !core_done) begin
      wait_cnt_q <= wait_cnt_q + 16'd1;
    end
  end

  // Sticky timeout flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (tmo_hit) begin
      err_q <= 1'b1;
    end
  end

  assign err_timeout = err_q;
`else
  assign tmo_hit     = 1'b0;
  assign err_timeout = 1'b0;
`endif

  // Next-state, index and buffer-write decisions.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    frame_cnt_d = frame_cnt_q;
    in_we       = 1'b0;
    out_we      = 1'b0;
    case (state_q)
      LOAD: begin
        if (in_valid) begin
          in_we = 1'b1;
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = START;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      START: begin
        state_d = WAIT;
      end
      WAIT: begin
        if (core_done) begin
          out_we  = 1'b1;
          idx_d   = '0;
          state_d = UNLOAD;
        end else if (tmo_hit) begin
          idx_d   = '0;
          state_d = LOAD;
        end
      end
      UNLOAD: begin
        if (out_ready) begin
          if (idx_q == LAST_IDX) begin
            idx_d       = '0;
            frame_cnt_d = frame_cnt_q + 16'd1;
            state_d     = LOAD;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      default: state_d = LOAD;
    endcase
  end

  // Control registers; core_start is a register so it is glitch-free toward the core.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= LOAD;
      idx_q        <= '0;
      frame_cnt_q  <= '0;
      core_start_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      frame_cnt_q  <= frame_cnt_d;
      core_start_q <= (state_d == START);
    end
  end

  // Sample buffer (written in LOAD) and result buffer (captured on done in WAIT).
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < N; k++) begin
        in_re_q[k]  <= '0;
        in_im_q[k]  <= '0;
        out_re_q[k] <= '0;
        out_im_q[k] <= '0;
      end
    end else begin
      if (in_we) begin
        in_re_q[idx_q] <= in_real;
        in_im_q[idx_q] <= in_imag;
      end
      if (out_we) begin
        for (int k = 0; k < N; k++) begin
          out_re_q[k] <= core_out_real[DW*k +: DW];
          out_im_q[k] <= core_out_imag[DW*k +: DW];
        end
      end
    end
  end

  // Continuous packing of the sample buffer toward the core.
  always_comb begin
    core_in_real = '0;
    core_in_imag = '0;
    for (int k = 0; k < N; k++) begin
      core_in_real[DW*k +: DW] = in_re_q[k];
      core_in_imag[DW*k +: DW] = in_im_q[k];
    end
  end

  assign in_ready   = (state_q == LOAD);
  assign out_valid  = (state_q == UNLOAD);
  assign out_last   = (state_q == UNLOAD) && (idx_q == LAST_IDX);
  assign out_real   = out_re_q[idx_q];
  assign out_imag   = out_im_q[idx_q];
  assign core_start = core_start_q;
  assign busy       = (state_q == START) || (state_q == WAIT);
  assign frame_cnt  = frame_cnt_q;
  assign dbg_state  = state_q;

endmodule

// File: doc/fft_8_frame_ctrl.md
Name: fft_8_frame_ctrl

Overview:
Frame sequencer wrapped around the 8-point FFT core (fft_8_sol1_gen1 port shape: clk, rst, start, 8x16-bit real/imag in, 8x16-bit real/imag out, done). Collects 8 complex samples from a valid/ready input stream and presents them as a parallel frame. Pulses the core start, waits for done, captures the result, then streams the 8 output bins back out in order. Sits between the sample source and the core, so the core can be driven by a serial streaming datapath.

Parameters:
DW, 16, sample component width (real and imag each)
N, 8, points per frame; fixed at 8, index width 3
TIMEOUT_CYCLES, 1024, max cycles in WAIT before abort (used only with FFT_CTRL_TIMEOUT_EN)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
in_valid  in  1  input sample valid
in_ready  out  1  controller accepts a sample
in_real  in  DW  input sample real part
in_imag  in  DW  input sample imag part
out_valid  out  1  output bin valid
out_ready  in  1  downstream accepts a bin
out_real  out  DW  output bin real part
out_imag  out  DW  output bin imag part
out_last  out  1  high with bin 7
core_start  out  1  one-cycle start pulse to FFT core
core_in_real  out  N*DW  packed frame; sample k at bits [DW*k+DW-1 : DW*k]
core_in_imag  out  N*DW  same packing
core_out_real  in  N*DW  packed core result, same packing
core_out_imag  in  N*DW  same packing
core_done  in  1  core result valid
busy  out  1  high in START or WAIT
frame_cnt  out  16  completed frames, wraps 0xFFFF->0
err_timeout  out  1  sticky timeout flag

Behaviour:
- FSM states: LOAD, START, WAIT, UNLOAD. Reset state: LOAD.
- Reset clears:
  - idx=0, frame_cnt=0, err_timeout=0.
  - core_start=0, out_valid=0, out_last=0.
  - Input and output buffers = 0.
  - in_ready=1, since the FSM resets to LOAD.
- LOAD:
  - in_ready=1.
  - On in_valid&&in_ready, write the sample to in_buf[idx] and increment idx.
  - On acceptance with idx==7: idx->0, go to START.
- START:
  - in_ready=0.
  - core_start is registered and high for exactly this one cycle.
  - Next state is WAIT.
- WAIT:
  - core_done is sampled only here.
  - On core_done: capture core_out_real/imag into out_buf, idx->0, go to UNLOAD.
  - core_done in any other state is ignored.
- UNLOAD:
  - out_valid=1, out_real/imag=out_buf[idx], out_last=(idx==7).
  - Data stays stable while out_valid&&!out_ready.
  - On out_valid&&out_ready: idx++.
  - On the transfer with idx==7: frame_cnt++, idx->0, go to LOAD.
- Latency, assuming the source never stalls and out_ready=1:
  - 8th sample accepted at cycle T; core_start high at T+1.
  - If core_done arrives at cycle D, bin 0 is valid at D+1 and bin 7 at D+8.
  - The next LOAD begins at D+9.
- No overlap: the input is back-pressured (in_ready=0) from START through the end of UNLOAD.
- core_in_real/imag are driven continuously from in_buf and are stable from START until the next LOAD write.
- in_valid held with in_ready=0: nothing is accepted and no data is lost.
- Reset asserted mid-frame (any state): the partial frame is discarded, all state returns to reset values, and core_start is forced to 0 on the next edge.

Optional Feature:
FFT_CTRL_TIMEOUT_EN
- Defined:
  - A 16-bit wait counter clears on entry to WAIT and increments each cycle in WAIT without core_done.
  - When it reaches TIMEOUT_CYCLES, err_timeout is set (sticky until rst) and the FSM returns to LOAD with idx=0.
  - The frame is dropped: no UNLOAD, frame_cnt unchanged.
  - If core_done arrives in the same cycle as the counter reaching TIMEOUT_CYCLES, core_done wins: no error is raised.
- Undefined:
  - No counter; WAIT holds indefinitely.
  - err_timeout is tied to 0.

Test Plan:
- Reset then feed samples k=0..7 with real=k, imag=0x100+k, no stalls; model core returns done 5 cycles after start -> core_start high exactly 1 cycle, one cycle after the 8th handshake; core_in_real=0x0007_0006_..._0000.
- Model core outputs real=0xA000+k, imag=0xB000+k with out_ready=1 -> 8 consecutive beats in order k=0..7; out_last only on k=7; frame_cnt=1.
- Toggle in_valid randomly and hold out_ready=0 for 4 cycles mid-unload -> no sample is lost or duplicated, out_real is held stable while stalled, frame completes, in_ready=0 throughout UNLOAD.
- Pulse core_done during LOAD and during UNLOAD -> no state change, no capture.
- Assert rst for 1 cycle after 5 samples loaded -> idx=0, in_ready=1, core_start=0; the next 8 samples form a clean frame.
- With FFT_CTRL_TIMEOUT_EN and TIMEOUT_CYCLES=16, core never returns done -> err_timeout rises after 16 WAIT cycles, out_valid never asserts, frame_cnt unchanged; the next frame with a working done completes normally and err_timeout stays 1.
